// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner for the ALU board.
// New display values are double-buffered and applied at frame boundaries.
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] Y_in,
    input  logic [3:0] OP_in,
    input  logic       blank,
    output logic [3:0] anode,
    output logic [6:0] segs,
    output logic       dp,
    output logic       frame_done,
    output logic       pending
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD_CNT = CW'(DEAD_CYCLES);

    // Active-low {g,f,e,d,c,b,a} pattern for a hex nibble.
    function automatic logic [6:0] hex_to_segs(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [CW-1:0] cnt_r;
    logic [1:0]    idx_r;
    logic [7:0]    act_y_r;
    logic [3:0]    act_op_r;
    logic [7:0]    buf_y_r;
    logic [3:0]    buf_op_r;
    logic          pending_r;
    logic [3:0]    anode_r;
    logic [6:0]    segs_r;
    logic          dp_r;
    logic          frame_done_r;

    logic          tick_s;
    logic          boundary_s;
    logic          digit_on_s;
    logic [3:0]    nibble_s;
    logic [3:0]    anode_sel_s;
    logic [3:0]    anode_nx_s;
    logic [6:0]    segs_nx_s;

    // Slot timing, boundary detect and next output values.
    always_comb begin
        tick_s      = (cnt_r == LAST_CNT);
        boundary_s  = tick_s && (idx_r == 2'd3);
        digit_on_s  = !blank && (cnt_r >= DEAD_CNT);
        nibble_s    = 4'h0;
        anode_sel_s = 4'b1111;
        case (idx_r)
            2'd0: begin nibble_s = act_op_r;     anode_sel_s = 4'b1110; end
            2'd1: begin nibble_s = 4'h0;         anode_sel_s = 4'b1101; end
            2'd2: begin nibble_s = act_y_r[3:0]; anode_sel_s = 4'b1011; end
            2'd3: begin nibble_s = act_y_r[7:4]; anode_sel_s = 4'b0111; end
            default: begin nibble_s = 4'h0;      anode_sel_s = 4'b1111; end
        endcase
        if (digit_on_s) begin
            anode_nx_s = anode_sel_s;
            segs_nx_s  = hex_to_segs(nibble_s);
        end else begin
            anode_nx_s = 4'b1111;
            segs_nx_s  = 7'b1111111;
        end
    end

    // Prescaler and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
            idx_r <= 2'd0;
        end else if (tick_s) begin
            cnt_r <= '0;
            idx_r <= idx_r + 2'd1;
        end else begin
            cnt_r <= cnt_r + CW'(1);
            idx_r <= idx_r;
        end
    end

    // Double buffer: a load on the boundary cycle bypasses straight to active.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_y_r   <= 8'h00;
            act_op_r  <= 4'h0;
            buf_y_r   <= 8'h00;
            buf_op_r  <= 4'h0;
            pending_r <= 1'b0;
        end else if (boundary_s && load) begin
            act_y_r   <= Y_in;
            act_op_r  <= OP_in;
            buf_y_r   <= Y_in;
            buf_op_r  <= OP_in;
            pending_r <= 1'b0;
        end else if (boundary_s && pending_r) begin
            act_y_r   <= buf_y_r;
            act_op_r  <= buf_op_r;
            pending_r <= 1'b0;
        end else if (load) begin
            buf_y_r   <= Y_in;
            buf_op_r  <= OP_in;
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            anode_r      <= 4'b1111;
            segs_r       <= 7'b1111111;
            dp_r         <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            anode_r      <= anode_nx_s;
            segs_r       <= segs_nx_s;
            dp_r         <= 1'b1;
            frame_done_r <= boundary_s;
        end
    end

    assign anode      = anode_r;
    assign segs       = segs_r;
    assign dp         = dp_r;
    assign frame_done = frame_done_r;
    assign pending    = pending_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: a cycle model feeds a scoreboard
// queue, and directed sequences check the display against the segment table.
module tb_seven_seg_scanner;

    localparam int RD = 8;
    localparam int DC = 2;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] Y_in;
    logic [3:0] OP_in;
    logic       blank;
    logic [3:0] anode;
    logic [6:0] segs;
    logic       dp;
    logic       frame_done;
    logic       pending;

    int tests;
    int failed;

    seven_seg_scanner #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .load(load), .Y_in(Y_in), .OP_in(OP_in),
        .blank(blank), .anode(anode), .segs(segs), .dp(dp),
        .frame_done(frame_done), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Segment table as written on the board documentation.
    logic [6:0] seg_tab [16];
    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
        seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
    end

    // Reference model state.
    int         m_cnt;
    int         m_idx;
    logic [7:0] m_y, m_by;
    logic [3:0] m_op, m_bop;
    logic       m_pend;
    logic [13:0] exp_q[$];

    function automatic logic [13:0] model_out(input logic r, input int c, input int ix,
                                              input logic [7:0] y, input logic [3:0] op,
                                              input logic bl, input logic pd, input logic ld);
        logic [3:0] an;
        logic [6:0] sg;
        logic [3:0] nib;
        logic       bnd;
        if (r) return {4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b0};
        bnd = (c == RD - 1) && (ix == 3);
        nib = (ix == 0) ? op : (ix == 1) ? 4'h0 : (ix == 2) ? y[3:0] : y[7:4];
        if (bl || c < DC) begin
            an = 4'b1111;
            sg = 7'b1111111;
        end else begin
            an = ~(4'b0001 << ix);
            sg = seg_tab[nib];
        end
        return {an, sg, 1'b1, bnd, bnd ? 1'b0 : (ld ? 1'b1 : pd)};
    endfunction

    // Model step: push the expected post-edge outputs, then advance the model.
    always @(posedge clk) begin
        exp_q.push_back(model_out(rst, m_cnt, m_idx, m_y, m_op, blank, m_pend, load));
        if (rst) begin
            m_cnt <= 0; m_idx <= 0; m_y <= 8'h00; m_op <= 4'h0;
            m_by <= 8'h00; m_bop <= 4'h0; m_pend <= 1'b0;
        end else begin
            m_cnt <= (m_cnt == RD - 1) ? 0 : m_cnt + 1;
            if (m_cnt == RD - 1) m_idx <= (m_idx + 1) % 4;
            if (m_cnt == RD - 1 && m_idx == 3 && load) begin
                m_y <= Y_in; m_op <= OP_in; m_pend <= 1'b0;
            end else if (m_cnt == RD - 1 && m_idx == 3 && m_pend) begin
                m_y <= m_by; m_op <= m_bop; m_pend <= 1'b0;
            end else if (load) begin
                m_by <= Y_in; m_bop <= OP_in; m_pend <= 1'b1;
            end
        end
    end

    // Scoreboard compare away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0)
            check_eq("scoreboard", {18'd0, anode, segs, dp, frame_done, pending}, {18'd0, exp_q.pop_front()});
    end

    task automatic wait_anode(input logic [3:0] a);
        int n = 0;
        while (anode !== a && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("wait_anode_timeout", {28'd0, anode}, {28'd0, a});
    endtask

    task automatic wait_fd();
        int n = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("wait_frame_done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int fd_cnt;
        tests = 0; failed = 0;
        rst = 1'b1; load = 1'b0; Y_in = 8'h00; OP_in = 4'h0; blank = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_anode", {28'd0, anode}, 32'hF);
        check_eq("reset_segs", {25'd0, segs}, 32'h7F);
        check_eq("reset_flags", {29'd0, dp, frame_done, pending}, 32'h4);

        // Startup: two dead edges, then digit 0 showing zero.
        rst = 1'b0;
        @(negedge clk); check_eq("start_e1_anode", {28'd0, anode}, 32'hF);
        @(negedge clk); check_eq("start_e2_anode", {28'd0, anode}, 32'hF);
        @(negedge clk); check_eq("start_e3_anode", {28'd0, anode}, 32'hE);
        check_eq("start_e3_segs", {25'd0, segs}, 32'h40);

        // Mid-frame load stays pending until the boundary.
        Y_in = 8'hA5; OP_in = 4'h3; load = 1'b1;
        @(negedge clk); load = 1'b0;
        check_eq("load_pending", {31'd0, pending}, 32'd1);
        wait_anode(4'b1011);
        check_eq("pre_boundary_d2", {25'd0, segs}, 32'h40);
        wait_fd();
        check_eq("post_boundary_pending", {31'd0, pending}, 32'd0);
        wait_anode(4'b1110); check_eq("a5_d0", {25'd0, segs}, 32'h30);
        wait_anode(4'b1011); check_eq("a5_d2", {25'd0, segs}, 32'h12);
        wait_anode(4'b0111); check_eq("a5_d3", {25'd0, segs}, 32'h08);

        // Two loads in one frame: last one wins.
        wait_fd();
        Y_in = 8'h12; load = 1'b1;
        @(negedge clk); Y_in = 8'hFE;
        @(negedge clk); load = 1'b0;
        wait_fd();
        wait_anode(4'b1011); check_eq("fe_d2", {25'd0, segs}, 32'h06);
        wait_anode(4'b0111); check_eq("fe_d3", {25'd0, segs}, 32'h0E);

        // Load exactly on the boundary cycle bypasses the pending buffer.
        wait_fd();
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            check_eq("bypass_pre_pending", {31'd0, pending}, 32'd0);
        end
        Y_in = 8'h0C; OP_in = 4'h0; load = 1'b1;
        @(negedge clk); load = 1'b0;
        check_eq("bypass_fd", {31'd0, frame_done}, 32'd1);
        check_eq("bypass_pending", {31'd0, pending}, 32'd0);
        wait_anode(4'b1011); check_eq("0c_d2", {25'd0, segs}, 32'h46);
        wait_anode(4'b0111); check_eq("0c_d3", {25'd0, segs}, 32'h40);

        // Blank for 40 cycles: display dark, frame timing continues.
        blank = 1'b1;
        fd_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check_eq("blank_anode", {28'd0, anode}, 32'hF);
            check_eq("blank_segs", {25'd0, segs}, 32'h7F);
            if (frame_done) fd_cnt++;
        end
        check_eq("blank_fd_count", {31'd0, (fd_cnt >= 1 && fd_cnt <= 2)}, 32'd1);
        blank = 1'b0;
        repeat (4) @(negedge clk);

        // Reset with a load pending discards it.
        wait_anode(4'b1110);
        Y_in = 8'h77; OP_in = 4'h7; load = 1'b1;
        @(negedge clk); load = 1'b0;
        check_eq("rst_pre_pending", {31'd0, pending}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_anode", {28'd0, anode}, 32'hF);
        check_eq("rst_mid_pending", {31'd0, pending}, 32'd0);
        rst = 1'b0;
        wait_anode(4'b1110); check_eq("restart_d0", {25'd0, segs}, 32'h40);
        wait_anode(4'b1011); check_eq("restart_d2", {25'd0, segs}, 32'h40);
        wait_anode(4'b0111); check_eq("restart_d3", {25'd0, segs}, 32'h40);

        repeat (40) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
